safe_cracker: RTL and testbench
===============================

SAFE_CRACKER -- requirements
Module: safe_cracker

Interface
REQ-001 Parameter WIDTH, default 10: bit width of the secret code and the probe.
REQ-002 Parameter HINT_LAT, default 1: number of clk cycles hint needs to settle after probe changes; range 0..7.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 RESETN  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  level-sampled request to begin a crack run; acted on only in IDLE or DONE.
REQ-006 hint  in  $clog2(WIDTH+1)  Hamming distance popcount(probe ^ secret) returned by the lock; 4 bits at the default width.
REQ-007 probe  out  WIDTH  candidate code presented to the lock; registered.
REQ-008 code  out  WIDTH  recovered secret; valid while done=1.
REQ-009 busy  out  1  high from the cycle after start is accepted until done or error is asserted.
REQ-010 done  out  1  run finished; code is verified.
REQ-011 error  out  1  run aborted: inconsistent or out-of-range hint.
REQ-012 state  out  3  present FSM state encoding, for LED display: IDLE=0, BASE=1, SCAN=2, VERIFY=3, DONE=4, ERR=5.

Function
REQ-013 The FSM shall have states IDLE, BASE, SCAN, VERIFY, DONE and ERR.
REQ-014 Every measurement shall drive probe for HINT_LAT+1 cycles and sample hint in the last cycle only.
REQ-015 IDLE, start=1: go to BASE with probe=0; clear code, the bit index and the settle counter.
REQ-016 BASE sample: store base=hint; go to SCAN with index=0 and probe=one-hot(0).
REQ-017 SCAN sample for index i: set code[i]=1 if hint<base, else code[i]=0.
REQ-018 After the SCAN sample for index i < WIDTH-1: increment index and set probe=one-hot(i+1).
REQ-019 After the SCAN sample for index WIDTH-1: go to VERIFY with probe=code, including the bit just resolved.
REQ-020 VERIFY sample: hint=0 goes to DONE; any other value goes to ERR.
REQ-021 Any sample with hint>WIDTH shall go to ERR immediately.
REQ-022 Any SCAN sample where |hint-base|!=1 shall go to ERR immediately.
REQ-023 done shall assert exactly (WIDTH+2)*(HINT_LAT+1) cycles after the clk edge that accepts start: 24 cycles at the defaults.
REQ-024 DONE and ERR shall hold code, probe, done and error until start=1.
REQ-025 start=1 in DONE or ERR shall restart exactly as from IDLE, clearing done and error in the same edge.
REQ-026 start while busy=1 shall be ignored.
REQ-027 hint values outside the sample cycle shall be ignored.
REQ-028 base=0 (secret all zeros) shall be legal: every SCAN sample then reads 1, so all code bits are 0.
REQ-029 done and error shall never be high together.
REQ-030 busy shall be low in IDLE, DONE and ERR.

Reset
REQ-031 RESETN=0 shall asynchronously force state=IDLE, probe=0, code=0, busy=0, done=0, error=0, and clear index, base and the settle counter.
REQ-032 Reset asserted mid-run shall abort the run with no residual state.
REQ-033 After RESETN deasserts, the first start shall begin a run normally.

Verification
Lock model for all scenarios: hint=popcount(probe^secret) registered, matching HINT_LAT=1; WIDTH=10.
REQ-034 secret=10'h2B5, pulse start -> done=1 at cycle 24, code=10'h2B5, error=0, busy low from that cycle.
REQ-035 secret=10'h000 -> base=0, done with code=10'h000; secret=10'h3FF -> base=10, done with code=10'h3FF.
REQ-036 Model forces hint=4'hF during SCAN -> error=1 on the next edge, done=0, busy=0.
REQ-037 Model corrupts the VERIFY hint to 1 -> state=ERR, error=1; start then rerun with a clean model -> done, code correct.
REQ-038 RESETN pulsed low at cycle 9 of a run -> all outputs are 0 asynchronously; restart -> done 24 cycles after start.
REQ-039 start held high for the whole run -> exactly one run; start still high in DONE -> immediate restart, done drops.

Source files
------------

// File: rtl/safe_cracker_if.sv
// Lock-side bus of the safe cracker: start request, the lock's hint back, and the
// probe, code and status outputs that go to the lock and the LED panel.
interface safe_cracker_if #(
    parameter int WIDTH = 10
);
    localparam int HW = $clog2(WIDTH + 1);

    logic             start;
    logic [HW-1:0]    hint;
    logic [WIDTH-1:0] probe;
    logic [WIDTH-1:0] code;
    logic             busy;
    logic             done;
    logic             error;
    logic [2:0]       state;

    modport master (
        output start, hint,
        input  probe, code, busy, done, error, state
    );

    modport slave (
        input  start, hint,
        output probe, code, busy, done, error, state
    );
endinterface

// File: rtl/safe_cracker.sv
// Recovers a WIDTH-bit secret from Hamming-distance hints: one all-zero base probe,
// one one-hot probe per bit, then a verify probe carrying the recovered code.
//
// state  | meaning
// IDLE   | waiting for start
// BASE   | probe=0, measuring base = popcount(secret)
// SCAN   | probe=one-hot(index), resolving code[index]
// VERIFY | probe=code, expecting hint=0
// DONE   | code verified, outputs held until start
// ERR    | inconsistent hint, outputs held until start
module safe_cracker #(
    parameter int WIDTH    = 10,
    parameter int HINT_LAT = 1
) (
    input  logic           clk,
    input  logic           RESETN,
    safe_cracker_if.slave  bus
);
    localparam int HW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [IW-1:0]    IDX_LAST = IW'(WIDTH - 1);
    localparam logic [2:0]       CNT_LOAD = 3'(HINT_LAT);
    localparam logic [HW-1:0]    HINT_MAX = HW'(WIDTH);
    localparam logic [HW:0]      ONE_E    = (HW+1)'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BASE   = 3'd1,
        S_SCAN   = 3'd2,
        S_VERIFY = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_probe;
    logic [WIDTH-1:0] r_code;
    logic [IW-1:0]    r_idx;
    logic [HW-1:0]    r_base;
    logic [2:0]       r_cnt;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_probe_nxt;
    logic [WIDTH-1:0] w_code_nxt;
    logic [IW-1:0]    w_idx_nxt;
    logic [HW-1:0]    w_base_nxt;
    logic [2:0]       w_cnt_nxt;

    logic             w_sample;
    logic             w_hint_bad;
    logic             w_step_bad;
    logic [HW:0]      w_hint_e;
    logic [HW:0]      w_base_e;
    logic [WIDTH-1:0] w_bit_mask;
    logic [WIDTH-1:0] w_code_scan;

    // The settle timer is a down-counter; hint is only trusted at terminal count.
    assign w_sample   = (r_cnt == 3'd0);
    assign w_hint_bad = (bus.hint > HINT_MAX);
    assign w_hint_e   = {1'b0, bus.hint};
    assign w_base_e   = {1'b0, r_base};
    assign w_step_bad = (w_hint_e != w_base_e + ONE_E) && (w_hint_e + ONE_E != w_base_e);
    assign w_bit_mask = ONE_W << r_idx;
    assign w_code_scan = (bus.hint < r_base) ? (r_code | w_bit_mask) : (r_code & ~w_bit_mask);

    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= S_IDLE;
            r_probe <= '0;
            r_code  <= '0;
            r_idx   <= '0;
            r_base  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_probe <= w_probe_nxt;
            r_code  <= w_code_nxt;
            r_idx   <= w_idx_nxt;
            r_base  <= w_base_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_probe_nxt = r_probe;
        w_code_nxt  = r_code;
        w_idx_nxt   = r_idx;
        w_base_nxt  = r_base;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    w_state_nxt = S_BASE;
                    w_probe_nxt = '0;
                    w_code_nxt  = '0;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_BASE: begin
                if (!w_sample) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else if (w_hint_bad) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_base_nxt  = bus.hint;
                    w_state_nxt = S_SCAN;
                    w_idx_nxt   = '0;
                    w_probe_nxt = ONE_W;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_SCAN: begin
                if (!w_sample) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else if (w_hint_bad || w_step_bad) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_code_nxt = w_code_scan;
                    w_cnt_nxt  = CNT_LOAD;
                    // The verify probe must include the bit resolved on this very edge.
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_VERIFY;
                        w_probe_nxt = w_code_scan;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_probe_nxt = ONE_W << (r_idx + 1'b1);
                    end
                end
            end
            S_VERIFY: begin
                if (!w_sample) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else if (bus.hint == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.probe = r_probe;
    assign bus.code  = r_code;
    assign bus.busy  = (r_state == S_BASE) || (r_state == S_SCAN) || (r_state == S_VERIFY);
    assign bus.done  = (r_state == S_DONE);
    assign bus.error = (r_state == S_ERR);
    assign bus.state = r_state;
endmodule

// File: tb/tb_safe_cracker.sv
// Bench for safe_cracker: a registered Hamming-distance lock model with fault
// injection, directed runs queued into a scoreboard, and a completion monitor.
module tb_safe_cracker;
    localparam int WIDTH    = 10;
    localparam int HINT_LAT = 1;
    localparam int HW       = $clog2(WIDTH + 1);
    localparam int LAT      = (WIDTH + 2) * (HINT_LAT + 1);

    typedef struct {
        logic             done;
        logic             err;
        logic [WIDTH-1:0] code;
        int               lat;
    } exp_t;

    logic clk    = 1'b0;
    logic RESETN = 1'b0;
    int   cyc    = 0;
    int   t_accept = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [WIDTH-1:0] secret;
    logic             force_f;
    logic             corrupt_v;
    logic             prev_fin = 1'b0;
    exp_t             sb[$];
    exp_t             mon_e;

    safe_cracker_if #(.WIDTH(WIDTH)) bus ();

    safe_cracker #(.WIDTH(WIDTH), .HINT_LAT(HINT_LAT)) dut (
        .clk    (clk),
        .RESETN (RESETN),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Lock: one register of latency, with optional hint corruption keyed off the LED state.
    always @(posedge clk or negedge RESETN) begin
        if (!RESETN)
            bus.hint <= '0;
        else if (force_f && bus.state == 3'd2)
            bus.hint <= 4'hF;
        else if (corrupt_v && bus.state == 3'd3)
            bus.hint <= 4'd1;
        else
            bus.hint <= HW'($countones(bus.probe ^ secret));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (!RESETN) begin
            prev_fin = 1'b0;
        end else begin
            if ((bus.done || bus.error) && !prev_fin) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_completion: done=%0b error=%0b with empty queue", bus.done, bus.error);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done", {31'd0, bus.done}, {31'd0, mon_e.done});
                    chk("error", {31'd0, bus.error}, {31'd0, mon_e.err});
                    chk("latency", cyc - t_accept, mon_e.lat);
                    chk("busy_at_end", {31'd0, bus.busy}, 32'd0);
                    chk("done_error_excl", {31'd0, bus.done & bus.error}, 32'd0);
                    if (mon_e.done) begin
                        chk("code", 32'(bus.code), 32'(mon_e.code));
                        chk("probe_eq_code", 32'(bus.probe), 32'(mon_e.code));
                    end
                end
            end
            prev_fin = bus.done || bus.error;
        end
    end

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 t_accept = cyc;
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.done || bus.error) break;
        end
        if (k == 200) begin
            n_checks++;
            $display("FAIL %s: timeout waiting for done/error", name);
        end
    endtask

    task automatic run(input string name, input logic [WIDTH-1:0] s, input exp_t e);
        secret = s;
        sb.push_back(e);
        do_start();
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(name);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        secret    = '0;
        force_f   = 1'b0;
        corrupt_v = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_probe", 32'(bus.probe), 32'd0);
        chk("rst_code", 32'(bus.code), 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_error", {31'd0, bus.error}, 32'd0);
        RESETN = 1'b1;
        repeat (2) @(negedge clk);

        // Basic run; a second start pulse mid-run must be ignored.
        secret = 10'h2B5;
        sb.push_back('{1'b1, 1'b0, 10'h2B5, LAT});
        do_start();
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_running", {31'd0, bus.busy}, 32'd1);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("run_2b5");
        repeat (5) @(negedge clk);
        chk("hold_done", {31'd0, bus.done}, 32'd1);
        chk("hold_code", 32'(bus.code), 32'h2B5);
        chk("hold_state", 32'(bus.state), 32'd4);

        run("run_000", 10'h000, '{1'b1, 1'b0, 10'h000, LAT});
        run("run_3ff", 10'h3FF, '{1'b1, 1'b0, 10'h3FF, LAT});

        // Out-of-range hint during SCAN aborts on the first SCAN sample.
        force_f = 1'b1;
        run("run_force_f", 10'h2B5, '{1'b0, 1'b1, 10'h000, 4});
        force_f = 1'b0;
        chk("force_f_state", 32'(bus.state), 32'd5);
        chk("force_f_done", {31'd0, bus.done}, 32'd0);

        // Corrupted verify hint, then a clean restart straight out of ERR.
        corrupt_v = 1'b1;
        run("run_corrupt", 10'h1C7, '{1'b0, 1'b1, 10'h000, LAT});
        corrupt_v = 1'b0;
        chk("corrupt_state", 32'(bus.state), 32'd5);
        secret = 10'h3A6;
        sb.push_back('{1'b1, 1'b0, 10'h3A6, LAT});
        do_start();
        chk("err_restart_error", {31'd0, bus.error}, 32'd0);
        chk("err_restart_state", 32'(bus.state), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("run_3a6");
        @(negedge clk);

        // Asynchronous reset in the middle of a run.
        secret = 10'h155;
        do_start();
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2 RESETN = 1'b0;
        #1;
        chk("mid_rst_state", 32'(bus.state), 32'd0);
        chk("mid_rst_probe", 32'(bus.probe), 32'd0);
        chk("mid_rst_code", 32'(bus.code), 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done_err", {30'd0, bus.done, bus.error}, 32'd0);
        @(negedge clk);
        RESETN = 1'b1;
        run("run_after_rst", 10'h155, '{1'b1, 1'b0, 10'h155, LAT});

        // start held high: one run, then an immediate restart from DONE.
        secret = 10'h0C3;
        sb.push_back('{1'b1, 1'b0, 10'h0C3, LAT});
        do_start();
        wait_done("run_held");
        sb.push_back('{1'b1, 1'b0, 10'h0C3, LAT});
        @(posedge clk);
        #1 t_accept = cyc;
        chk("held_restart_done", {31'd0, bus.done}, 32'd0);
        chk("held_restart_state", 32'(bus.state), 32'd1);
        chk("held_restart_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("run_held2");
        repeat (2) @(negedge clk);

        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d expected completions never seen", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
